fb_arbiter: RTL and testbench
=============================

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 4, write-request FIFO entries (power of two, 2..16).
REQ-002 SHALL provide parameter H_ACTIVE, default 640, pixels per line; V_ACTIVE, default 480, lines per frame.
REQ-003 clk_25  in  1  pixel clock; the single clock; all logic on rising edge.
REQ-004 n_rst  in  1  reset, synchronous, active-low.
REQ-005 x_coordinate  in  10  scan column from the VGA controller.
REQ-006 y_coordinate  in  10  scan row from the VGA controller.
REQ-007 video_on  in  1  scan is in the active area this cycle.
REQ-008 wr_valid  in  1  host write request.
REQ-009 wr_x / wr_y  in  10 / 10  host write coordinates.
REQ-010 wr_data  in  24  host pixel {R,G,B}.
REQ-011 wr_ready  out  1  FIFO can accept; transfer when wr_valid & wr_ready.
REQ-012 wr_drop  out  1  one-cycle pulse: an accepted write was discarded as out of range.
REQ-013 ram_address  out  19  frame RAM address, registered.
REQ-014 ram_wren  out  1  frame RAM write enable, registered.
REQ-015 ram_data  out  24  frame RAM write data, registered.
REQ-016 ram_q  in  24  frame RAM read data, one clock after ram_address (registered RAM output).
REQ-017 pixel_data  out  24  scan pixel to the DAC.
REQ-018 pixel_valid  out  1  pixel_data is an active-area pixel (video_on delayed 2).

Function
REQ-019 Address SHALL be y*640+x computed as (y<<9)+(y<<7)+x, 19 bits, no multiplier.
REQ-020 FSM states S_IDLE, S_SCAN, S_WRITE; the state register holds the port grant driven into the RAM registers this cycle.
REQ-021 Any state -> S_SCAN when video_on=1; scan SHALL always win, even with FIFO full.
REQ-022 video_on=0 and FIFO non-empty -> S_WRITE; video_on=0 and FIFO empty -> S_IDLE.
REQ-023 S_SCAN: next ram_address = scan address, ram_wren=0.
REQ-024 S_WRITE: pop one FIFO entry per cycle; next ram_address = its address, ram_data = its data, ram_wren=1.
REQ-025 S_IDLE: ram_wren=0, ram_address holds its previous value.
REQ-026 Scan latency SHALL be exactly 2 cycles: coordinates at cycle N -> pixel_data at N+2; pixel_valid = video_on delayed 2.
REQ-027 pixel_data SHALL be 24'h0 whenever pixel_valid=0.
REQ-028 wr_ready = FIFO not full; push and pop in the same cycle on a full FIFO SHALL NOT be allowed (wr_ready=0 when full regardless of pop).
REQ-029 Simultaneous push and pop on a non-full, non-empty FIFO SHALL keep count unchanged; push on empty SHALL NOT pop the same cycle (1-cycle bypass-free).
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; entries SHALL be written to RAM in acceptance order.
REQ-031 A write pending at video_on rise SHALL stay in the FIFO and resume in the next blanking interval, never lost or duplicated.

Reset
REQ-032 While n_rst=0 at a clock edge: state S_IDLE, FIFO emptied, ram_wren=0, ram_address=0, ram_data=0, pixel_data=0, pixel_valid=0, wr_drop=0, wr_ready=0.
REQ-033 wr_ready SHALL rise the first cycle after n_rst=1; reset mid-write SHALL discard all queued entries and deassert ram_wren on the next edge.

Configuration
REQ-034 Macro FB_WR_CLIP_EN: when defined, accepted writes with wr_x>=H_ACTIVE or wr_y>=V_ACTIVE SHALL be discarded at push, not queued, and wr_drop pulses the following cycle.
REQ-035 Without FB_WR_CLIP_EN: no range check, all accepted writes queued, address computed per REQ-019 truncated to 19 bits, wr_drop tied 0.

Verification
REQ-036 Reset: hold n_rst=0 3 cycles with wr_valid=1 -> ram_wren=0, wr_ready=0, pixel_valid=0 throughout; wr_ready=1 one cycle after release.
REQ-037 Scan: video_on=1, x=5, y=2 at cycle N -> ram_address=1285 at N+1; ram_q=24'hA1B2C3 at N+2 -> pixel_data=24'hA1B2C3, pixel_valid=1.
REQ-038 Blanking write: video_on=0, push (x=639,y=479,data 24'hFFFFFF) -> ram_wren=1, ram_address=307199, ram_data=24'hFFFFFF within 2 cycles.
REQ-039 Priority/full: video_on=1 held, push 5 writes with FIFO_DEPTH=4 -> 4 accepted, wr_ready=0 on fifth, no ram_wren; video_on=0 -> 4 consecutive ram_wren cycles in push order.
REQ-040 Clip (FB_WR_CLIP_EN): push x=640,y=0 -> wr_drop=1 one cycle, FIFO count unchanged, no ram_wren; without macro -> ram_wren with address 640.

Source files
------------

// File: rtl/fb_arbiter.sv
// fb_arbiter: frame-RAM port arbiter between VGA scan reads and FIFO-queued host pixel writes.
// Optional macro FB_WR_CLIP_EN discards out-of-range host writes at push and pulses wr_drop.
module fb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480
) (
  input  logic        clk_25,
  input  logic        n_rst,
  input  logic [9:0]  x_coordinate,
  input  logic [9:0]  y_coordinate,
  input  logic        video_on,
  input  logic        wr_valid,
  input  logic [9:0]  wr_x,
  input  logic [9:0]  wr_y,
  input  logic [23:0] wr_data,
  output logic        wr_ready,
  output logic        wr_drop,
  output logic [18:0] ram_address,
  output logic        ram_wren,
  output logic [23:0] ram_data,
  input  logic [23:0] ram_q,
  output logic [23:0] pixel_data,
  output logic        pixel_valid
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      H_ACTIVE > 1024 || V_ACTIVE > 1024) begin : g_param_check
    $error("fb_arbiter: illegal parameter value");
  end

  // y*640 + x without a multiplier.
  function automatic logic [18:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    logic [18:0] y_ext;
    y_ext = {9'd0, y};
    return (y_ext << 9) + (y_ext << 7) + {9'd0, x};
  endfunction

  logic [18:0]   mem_addr_q [FIFO_DEPTH];
  logic [23:0]   mem_data_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic          ready_q;
  logic          vo_d1_q, pixel_valid_q;
  logic [18:0]   ram_address_q, ram_address_d;
  logic [23:0]   ram_data_q, ram_data_d;
  logic          ram_wren_q, ram_wren_d;
  logic          full, empty, accept, push, pop;

  assign full     = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign wr_ready = ready_q & ~full;
  assign accept   = wr_valid & wr_ready;

`ifdef FB_WR_CLIP_EN
  logic in_range, drop_q;
  assign in_range = (32'(wr_x) < H_ACTIVE) && (32'(wr_y) < V_ACTIVE);
  assign push     = accept & in_range;
  assign wr_drop  = drop_q;

  always_ff @(posedge clk_25) begin
    if (!n_rst) drop_q <= 1'b0;
    else        drop_q <= accept & ~in_range;
  end
`else
  assign push    = accept;
  assign wr_drop = 1'b0;
`endif

  // Scan always wins; queued writes only drain during blanking.
  always_comb begin
    state_d = S_IDLE;
    if (video_on)    state_d = S_SCAN;
    else if (!empty) state_d = S_WRITE;
  end

  assign pop = (state_d == S_WRITE);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
  end

  always_comb begin
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    unique case (state_d)
      S_SCAN:  ram_address_d = pix_addr(x_coordinate, y_coordinate);
      S_WRITE: begin
        ram_address_d = mem_addr_q[rd_ptr_q];
        ram_data_d    = mem_data_q[rd_ptr_q];
        ram_wren_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_25) begin
    if (!n_rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ready_q       <= 1'b0;
      vo_d1_q       <= 1'b0;
      pixel_valid_q <= 1'b0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ready_q       <= 1'b1;
      vo_d1_q       <= video_on;
      pixel_valid_q <= vo_d1_q;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk_25) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= pix_addr(wr_x, wr_y);
      mem_data_q[wr_ptr_q] <= wr_data;
    end
  end

  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_data  = pixel_valid_q ? ram_q : 24'h0;

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed and randomized checks of fb_arbiter against a queue-based reference.
module tb_fb_arbiter;

  localparam int unsigned DEPTH = 4;
`ifdef FB_WR_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic        clk_25 = 1'b0;
  logic        n_rst;
  logic [9:0]  x_coordinate, y_coordinate;
  logic        video_on;
  logic        wr_valid;
  logic [9:0]  wr_x, wr_y;
  logic [23:0] wr_data;
  logic        wr_ready, wr_drop;
  logic [18:0] ram_address;
  logic        ram_wren;
  logic [23:0] ram_data, ram_q, pixel_data;
  logic        pixel_valid;

  always #20 clk_25 = ~clk_25;

  fb_arbiter #(.FIFO_DEPTH(DEPTH), .H_ACTIVE(640), .V_ACTIVE(480)) dut (
    .clk_25      (clk_25),
    .n_rst       (n_rst),
    .x_coordinate(x_coordinate),
    .y_coordinate(y_coordinate),
    .video_on    (video_on),
    .wr_valid    (wr_valid),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .wr_drop     (wr_drop),
    .ram_address (ram_address),
    .ram_wren    (ram_wren),
    .ram_data    (ram_data),
    .ram_q       (ram_q),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid)
  );

  typedef struct {
    logic [18:0] addr;
    logic [23:0] data;
  } wr_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  wr_t         m_q[$];
  bit          m_ready = 1'b0;
  logic        e_wren = 1'b0, e_drop = 1'b0, e_pv = 1'b0, vo_d1 = 1'b0;
  logic [18:0] e_addr = '0;
  logic [23:0] e_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: update the reference from pre-edge inputs, then compare.
  task automatic step();
    bit acc, inr;
    acc = n_rst && wr_valid && m_ready && (m_q.size() < DEPTH);
    inr = (wr_x < 640) && (wr_y < 480);
    if (!n_rst) begin
      m_q.delete();
      e_wren = 0; e_addr = '0; e_data = '0; e_pv = 0; vo_d1 = 0; e_drop = 0;
    end else begin
      e_drop = CLIP && acc && !inr;
      if (!video_on && m_q.size() > 0) begin
        e_wren = 1;
        e_addr = m_q[0].addr;
        e_data = m_q[0].data;
        void'(m_q.pop_front());
      end else begin
        e_wren = 0;
        if (video_on) e_addr = 19'(int'(y_coordinate) * 640 + int'(x_coordinate));
      end
      if (acc && !(CLIP && !inr))
        m_q.push_back('{addr: 19'(int'(wr_y) * 640 + int'(wr_x)), data: wr_data});
      e_pv  = vo_d1;
      vo_d1 = video_on;
    end
    m_ready = n_rst;
    @(posedge clk_25);
    #1;
    chk("wr_ready", 32'(wr_ready), 32'(m_ready && (m_q.size() < DEPTH)));
    chk("wr_drop", 32'(wr_drop), 32'(e_drop));
    chk("ram_wren", 32'(ram_wren), 32'(e_wren));
    chk("ram_address", 32'(ram_address), 32'(e_addr));
    chk("ram_data", 32'(ram_data), 32'(e_data));
    chk("pixel_valid", 32'(pixel_valid), 32'(e_pv));
    chk("pixel_data", 32'(pixel_data), 32'(e_pv ? ram_q : 24'h0));
  endtask

  initial begin
    n_rst = 0; video_on = 0; wr_valid = 1;
    x_coordinate = 10'd0; y_coordinate = 10'd0;
    wr_x = 10'd3; wr_y = 10'd4; wr_data = 24'h123456; ram_q = 24'h0;

    // Reset held three cycles with a write request pending.
    repeat (3) step();
    n_rst = 1; wr_valid = 0;
    step();
    chk("rst_release_ready", 32'(wr_ready), 32'd1);

    // Scan: address one cycle later, pixel two cycles later.
    video_on = 1; x_coordinate = 10'd5; y_coordinate = 10'd2;
    step();
    chk("scan_addr", 32'(ram_address), 32'd1285);
    video_on = 0; ram_q = 24'hA1B2C3;
    step();
    chk("scan_pixel", 32'(pixel_data), 32'hA1B2C3);
    chk("scan_pixel_valid", 32'(pixel_valid), 32'd1);

    // Blanking write at the last pixel.
    wr_valid = 1; wr_x = 10'd639; wr_y = 10'd479; wr_data = 24'hFFFFFF;
    step();
    wr_valid = 0;
    step();
    chk("blank_wren", 32'(ram_wren), 32'd1);
    chk("blank_addr", 32'(ram_address), 32'd307199);
    chk("blank_data", 32'(ram_data), 32'hFFFFFF);
    step();

    // Scan holds the port while the FIFO fills; drain in order once blanking starts.
    video_on = 1;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1; wr_x = 10'(10 + i); wr_y = 10'(i); wr_data = 24'(24'hC0 + i);
      if (i == 4) chk("full_not_ready", 32'(wr_ready), 32'd0);
      step();
    end
    wr_valid = 0; video_on = 0;
    repeat (5) step();

    // Out-of-range write: clipped or queued depending on build.
    wr_valid = 1; wr_x = 10'd640; wr_y = 10'd0; wr_data = 24'h00BEEF;
    step();
    wr_valid = 0;
    repeat (3) step();

    // Randomized traffic with bursty blanking and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      n_rst        = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 19) == 0) video_on = ~video_on;
      x_coordinate = 10'($urandom_range(0, 639));
      y_coordinate = 10'($urandom_range(0, 479));
      wr_valid     = 1'($urandom_range(0, 1));
      wr_x         = 10'($urandom_range(0, 700));
      wr_y         = 10'($urandom_range(0, 520));
      wr_data      = 24'($urandom);
      ram_q        = 24'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
